// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter sharing one external combinational ALU
// among NUM_REQ valid/ready requesters. Operands are registered toward the ALU,
// DIV (opcode 4) holds the ALU for DIV_LATENCY cycles, and the captured
// result/flags return with the requester ID on a valid/ready response channel.
// Optional build macro ALU_SCHED_PERF_EN adds saturating busy-cycle and grant
// counters (perf_busy_cycles, perf_grants).
module alu_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 16,
  parameter int SHIFT_W     = 5,
  parameter int DIV_LATENCY = 4,
  parameter int ID_W        = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4*NUM_REQ-1:0]       req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  input  logic [SHIFT_W*NUM_REQ-1:0] req_shift,
  output logic [3:0]                 alu_opcode,
  output logic [WIDTH-1:0]           alu_input1,
  output logic [WIDTH-1:0]           alu_input2,
  output logic [SHIFT_W-1:0]         alu_shift,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  input  logic                       alu_sign,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [2:0]                 rsp_flags,
  output logic                       busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_busy_cycles,
  output logic [31:0]                perf_grants
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_DIV = 4'd4;
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);
  localparam int SW = ID_W + 1;

  logic [1:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]       cnt;

  logic                   found;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        next_ptr;
  logic [2*NUM_REQ-1:0]   rot_valid;
  logic [SW-1:0]          sum;
  logic [SW-1:0]          nsum;

  logic [3:0]             sel_op;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       sel_b;
  logic [SHIFT_W-1:0]     sel_shift;

  // Round-robin search: rotate valids so rr_ptr sits at bit 0, take the first
  // set bit as an offset, then map the offset back to a requester index.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    sum       = '0;
    rot_valid = {req_valid, req_valid} >> rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        sum   = SW'(rr_ptr) + SW'(k);
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
        winner = sum[ID_W-1:0];
      end
    end
    nsum = SW'(winner) + SW'(1);
    if (nsum >= SW'(NUM_REQ)) nsum = '0;
    next_ptr = nsum[ID_W-1:0];
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_shift = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op    = req_opcode[i*4 +: 4];
        sel_a     = req_a[i*WIDTH +: WIDTH];
        sel_b     = req_b[i*WIDTH +: WIDTH];
        sel_shift = req_shift[i*SHIFT_W +: SHIFT_W];
      end
    end
  end

  // Grant only the winner, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found) req_ready = NUM_REQ'(1) << winner;
  end

  assign busy = (state != S_IDLE);

  // Scheduler FSM: accept, hold ALU operands for the op latency, return response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_shift  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            alu_opcode <= sel_op;
            alu_input1 <= sel_a;
            alu_input2 <= sel_b;
            alu_shift  <= sel_shift;
            rsp_id     <= winner;
            rr_ptr     <= next_ptr;
            cnt        <= (sel_op == OP_DIV) ? DIV_CNT : '0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_carry, alu_zero, alu_sign};
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_PERF_EN
  // Saturating activity counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_grants      <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_IDLE && found && perf_grants != '1) perf_grants <= perf_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: self-checking bench for alu_rr_scheduler with a local
// combinational ALU model, a vector table, a response scoreboard and
// hand-written sequences for round-robin, backpressure and reset-abort cases.
module tb_alu_rr_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int WIDTH       = 16;
  localparam int SHIFT_W     = 5;
  localparam int DIV_LATENCY = 4;
  localparam int ID_W        = 2;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [4*NUM_REQ-1:0]       req_opcode;
  logic [WIDTH*NUM_REQ-1:0]   req_a;
  logic [WIDTH*NUM_REQ-1:0]   req_b;
  logic [SHIFT_W*NUM_REQ-1:0] req_shift;
  logic [3:0]                 alu_opcode;
  logic [WIDTH-1:0]           alu_input1;
  logic [WIDTH-1:0]           alu_input2;
  logic [SHIFT_W-1:0]         alu_shift;
  logic [WIDTH-1:0]           alu_result;
  logic                       alu_carry;
  logic                       alu_zero;
  logic                       alu_sign;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [WIDTH-1:0]           rsp_result;
  logic [2:0]                 rsp_flags;
  logic                       busy;
`ifdef ALU_SCHED_PERF_EN
  logic [31:0]                perf_busy_cycles;
  logic [31:0]                perf_grants;
`endif

  alu_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SHIFT_W(SHIFT_W),
    .DIV_LATENCY(DIV_LATENCY), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_grants(perf_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 DIV, 5 NOR, 6 SLL, 7 SRL, else 0.
  logic [16:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    case (alu_opcode)
      4'd0: alu_tmp = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1: alu_tmp = {(alu_input1 < alu_input2), alu_input1 - alu_input2};
      4'd2: alu_tmp = {1'b0, alu_input1 & alu_input2};
      4'd3: alu_tmp = {1'b0, alu_input1 | alu_input2};
      4'd4: alu_tmp = {1'b0, (alu_input2 == '0) ? 16'hFFFF : alu_input1 / alu_input2};
      4'd5: alu_tmp = {1'b0, ~(alu_input1 | alu_input2)};
      4'd6: alu_tmp = {1'b0, alu_input1 << alu_shift};
      4'd7: alu_tmp = {1'b0, alu_input1 >> alu_shift};
      default: alu_tmp = '0;
    endcase
    alu_result = alu_tmp[15:0];
    alu_carry  = alu_tmp[16];
    alu_zero   = (alu_tmp[15:0] == '0);
    alu_sign   = alu_tmp[15];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     res;
    logic [2:0]      fl;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard: compare every accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got id=%0d result=0x%0h expected no response", rsp_id, rsp_result);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        check("rsp_flags", 32'(rsp_flags), 32'(mon_e.fl));
      end
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  sh;
    logic [15:0] res;
    logic [2:0]  fl;
    int          lat;
  } vec_t;
  vec_t vt[12];

  function automatic vec_t mkv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [4:0] sh, input logic [15:0] res, input logic [2:0] fl,
                               input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.fl = fl; v.lat = lat;
    return v;
  endfunction

  task automatic drive_req(input int r, input vec_t v);
    req_opcode[r*4 +: 4]             = v.op;
    req_a[r*WIDTH +: WIDTH]          = v.a;
    req_b[r*WIDTH +: WIDTH]          = v.b;
    req_shift[r*SHIFT_W +: SHIFT_W]  = v.sh;
  endtask

  task automatic wait_hs(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL hs_timeout: got no handshake expected one within 50 cycles");
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clk);
    #1;
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Issue one request from requester r, check grant and response latency.
  task automatic run_one(input int r, input vec_t v, input string name);
    int idx;
    bit ok;
    int lat;
    bit got;
    @(posedge clk) #1;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    drive_req(r, v);
    wait_hs(idx, ok);
    if (!ok) begin
      req_valid = '0;
      return;
    end
    check({name, "_grant"}, 32'(idx), 32'(r));
    sb.push_back(exp_t'{ID_W'(r), v.res, v.fl});
    @(posedge clk) #1;
    req_valid = '0;
    lat = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    check({name, "_lat"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(v.lat));
    @(posedge clk) #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int idx;
    bit ok;
    int unsigned last;
    int seen;
    bit got;
    vec_t vand;

    vt[0]  = mkv(4'd0,  16'hFFFF, 16'h0001, 5'd0,  16'h0000, 3'b110, 2);
    vt[1]  = mkv(4'd0,  16'h7FFF, 16'h0001, 5'd0,  16'h8000, 3'b001, 2);
    vt[2]  = mkv(4'd1,  16'h0005, 16'h0007, 5'd0,  16'hFFFE, 3'b101, 2);
    vt[3]  = mkv(4'd2,  16'h00FF, 16'h0F0F, 5'd0,  16'h000F, 3'b000, 2);
    vt[4]  = mkv(4'd3,  16'h00F0, 16'h0F00, 5'd0,  16'h0FF0, 3'b000, 2);
    vt[5]  = mkv(4'd4,  16'd100,  16'd7,    5'd0,  16'd14,   3'b000, 1 + DIV_LATENCY);
    vt[6]  = mkv(4'd5,  16'hFFFF, 16'h0000, 5'd0,  16'h0000, 3'b010, 2);
    vt[7]  = mkv(4'd6,  16'h0001, 16'h0000, 5'd15, 16'h8000, 3'b001, 2);
    vt[8]  = mkv(4'd7,  16'h8000, 16'h0000, 5'd15, 16'h0001, 3'b000, 2);
    vt[9]  = mkv(4'd12, 16'h1234, 16'h5678, 5'd3,  16'h0000, 3'b010, 2);
    vt[10] = mkv(4'd1,  16'h0009, 16'h0009, 5'd0,  16'h0000, 3'b010, 2);
    vt[11] = mkv(4'd4,  16'hFFFF, 16'h0010, 5'd0,  16'h0FFF, 3'b000, 1 + DIV_LATENCY);
    vand   = vt[3];

    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_shift  = '0;
    rsp_ready  = 1'b1;

    // Reset state.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_in1", 32'(alu_input1), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    // Table-driven vectors, rotating through the requesters.
    for (int i = 0; i < 12; i++) run_one(i % NUM_REQ, vt[i], $sformatf("vec%0d", i));
    drain("table");

    // All requesters valid: round-robin order 0,1,2,3,0 with 3-cycle spacing.
    @(posedge clk) #1;
    for (int r = 0; r < NUM_REQ; r++) drive_req(r, vand);
    req_valid = '1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_hs(idx, ok);
      if (!ok) break;
      check("rr_id", 32'(idx), 32'(g % NUM_REQ));
      if (g > 0) check("rr_gap", cyc - last, 32'd3);
      last = cyc;
      sb.push_back(exp_t'{ID_W'(g % NUM_REQ), 16'h000F, 3'b000});
    end
    @(posedge clk) #1;
    req_valid = '0;
    drain("rr");

    // Backpressure: requester 1 SRL held for 6 cycles while requester 0 waits.
    @(posedge clk) #1;
    rsp_ready    = 1'b0;
    req_valid    = '0;
    req_valid[1] = 1'b1;
    drive_req(1, vt[8]);
    wait_hs(idx, ok);
    check("bp_grant", 32'(idx), 32'd1);
    sb.push_back(exp_t'{ID_W'(1), 16'h0001, 3'b000});
    @(posedge clk) #1;
    req_valid    = '0;
    req_valid[0] = 1'b1;
    drive_req(0, vt[6]);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_result", 32'(rsp_result), 32'h0001);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      if (k < 5) @(negedge clk);
    end
    @(posedge clk) #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_accept", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_ready_after", 32'(req_ready), 32'b0001);
    sb.push_back(exp_t'{ID_W'(0), 16'h0000, 3'b010});
    @(posedge clk) #1;
    req_valid = '0;
    drain("bp");

    // Reset while a DIV from requester 2 is in EXEC: dropped, pointer back to 0.
    @(posedge clk) #1;
    req_valid    = '0;
    req_valid[2] = 1'b1;
    drive_req(2, vt[5]);
    wait_hs(idx, ok);
    check("rstdiv_grant", 32'(idx), 32'd2);
    @(posedge clk) #1;
    req_valid = '0;
    @(posedge clk) #1;
    check("rstdiv_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstdiv_busy", 32'(busy), 32'd0);
    check("rstdiv_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstdiv_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rstdiv_alu_in1", 32'(alu_input1), 32'd0);
    check("rstdiv_alu_in2", 32'(alu_input2), 32'd0);
    check("rstdiv_alu_shift", 32'(alu_shift), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rstdiv_no_rsp", 32'(seen), 32'd0);
    @(posedge clk) #1;
    for (int r = 0; r < NUM_REQ; r++) drive_req(r, vand);
    req_valid = '1;
    wait_hs(idx, ok);
    check("rstdiv_next_grant", 32'(idx), 32'd0);
    if (ok) sb.push_back(exp_t'{ID_W'(0), 16'h000F, 3'b000});
    @(posedge clk) #1;
    req_valid = '0;
    drain("rstdiv");

`ifdef ALU_SCHED_PERF_EN
    // Counters after a fresh reset and ten non-DIV operations.
    @(posedge clk) #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    check("perf_rst_grants", perf_grants, 32'd0);
    begin
      int n_ops;
      n_ops = 0;
      for (int i = 0; i < 12; i++) begin
        if (vt[i].op != 4'd4) begin
          run_one(n_ops % NUM_REQ, vt[i], $sformatf("perf%0d", n_ops));
          n_ops++;
        end
      end
    end
    drain("perf");
    check("perf_grants", perf_grants, 32'd10);
    check("perf_busy_cycles", perf_busy_cycles, 32'd20);
`endif

    check("sb_empty_final", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 16-bit ALU (opcode/input1/input2/shiftValue -> result + carry/zero/sign) among NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels; drives the ALU from registered operands.
- Applies a multi-cycle hold for DIV and returns the captured result/flags with the requester ID on a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- SHIFT_W, 5, shift amount width
- DIV_LATENCY, 4, cycles the ALU is held for opcode 4'd4 (DIV); minimum 1
- ID_W, 2, response ID width; must satisfy 2^ID_W >= NUM_REQ

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_opcode  in  4*NUM_REQ  flattened opcodes, requester i at [4i+3:4i]
- req_a  in  WIDTH*NUM_REQ  flattened operand A
- req_b  in  WIDTH*NUM_REQ  flattened operand B
- req_shift  in  SHIFT_W*NUM_REQ  flattened shift amount
- alu_opcode  out  4  to ALU opcode, registered
- alu_input1  out  WIDTH  to ALU input1, registered
- alu_input2  out  WIDTH  to ALU input2, registered
- alu_shift  out  SHIFT_W  to ALU shiftValue, registered
- alu_result  in  WIDTH  from ALU result
- alu_carry  in  1  from ALU carryFlag
- alu_zero  in  1  from ALU zeroFlag
- alu_sign  in  1  from ALU signFlag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester served
- rsp_result  out  WIDTH  captured ALU result
- rsp_flags  out  3  {carry, zero, sign} captured
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync-free deassert):
  - state=IDLE; rr_ptr=0.
  - All alu_* outputs, rsp_valid, rsp_id, rsp_result, rsp_flags and busy = 0.
  - Any in-flight operation is dropped, with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is combinational and asserted only for the winner; all zero in EXEC/RESP.
  - On handshake (valid&ready): latch opcode/a/b/shift into the alu_* registers; latch winner into the ID register; rr_ptr <= (winner+1) mod NUM_REQ.
  - Load cnt = DIV_LATENCY-1 if opcode==4'd4, else 0; go to EXEC.
- EXEC:
  - alu_* held stable. If cnt != 0, decrement.
  - If cnt==0: capture alu_result and {alu_carry, alu_zero, alu_sign} into the rsp registers; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid <= 0; go to IDLE.
- Timing:
  - Non-DIV: handshake cycle N, rsp_valid high from cycle N+2.
  - DIV: rsp_valid high from cycle N+1+DIV_LATENCY.
  - Minimum issue interval: 3 cycles (non-DIV, rsp_ready tied high).
- Opcodes 8..15 are passed through unchanged; the scheduler does not filter them. Result/flags are whatever the ALU returns (normally result 0, zero=1).
- req_* may change or deassert freely when not granted; the scheduler samples only on handshake.
- A request that deasserts before grant is simply not served; rr_ptr is unchanged.
- Fairness: a continuously valid requester is served within NUM_REQ grants.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- When defined:
  - Adds output perf_busy_cycles (32 bits), incremented every cycle busy==1, saturating at 0xFFFFFFFF.
  - Adds output perf_grants (32 bits), incremented on each request handshake, saturating.
  - Both are cleared only by rst_n.
- When undefined: neither port exists; no counter logic is instantiated.

Test Plan:
- All four req_valid held high, ops AND a=0x00FF b=0x0F0F, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; each rsp_result=0x000F; grants 3 cycles apart.
- Requester 2 DIV a=100 b=7, DIV_LATENCY=4 -> rsp_valid exactly 5 cycles after handshake; rsp_result=14; rsp_flags zero=0.
- Requester 1 SRL a=0x8000 shift=15, rsp_ready low 6 cycles -> rsp_valid, rsp_result=0x0001 and rsp_id=1 stable all 6 cycles; req_ready stays 0 until accept+1.
- Requester 0 NOR a=0xFFFF b=0 -> rsp_result=0, rsp_flags zero=1, sign=0; opcode 4'd12 -> rsp_result=0.
- rst_n pulsed low mid-DIV in EXEC -> immediately busy=0, rsp_valid=0, alu_*=0; no response after release; next grant goes to requester 0.
- With ALU_SCHED_PERF_EN, 10 non-DIV ops, rsp_ready=1 -> perf_grants=10, perf_busy_cycles=20.
